// File: rtl/registered_input_pipe_pkg.sv
// ============================================================================
// Module  : registered_input_pipe_pkg
// Brief   : Shared slice-state encoding and count-width helper for the pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package registered_input_pipe_pkg;

    // The encoding doubles as the slice occupancy, so EMPTY/ONE/TWO = 0/1/2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_e;

    localparam int OCC_W = 2;

    function automatic int count_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage : registered_input_pipe_pkg

`default_nettype wire

// File: rtl/skid_slice.sv
// ============================================================================
// Module  : skid_slice
// Brief   : Two-entry skid register slice; all outputs come straight from flops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_slice
    import registered_input_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [OCC_W-1:0] o_occ
);

    slice_state_e     state_q;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = i_valid & ready_q;
    assign w_out_xfer = valid_q & i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    // ready_q is low only for the first cycle after reset
                    ready_q <= 1'b1;
                    if (w_in_xfer) begin
                        state_q <= ONE;
                        main_q  <= i_data;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        state_q <= TWO;
                        skid_q  <= i_data;
                        ready_q <= 1'b0;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end else if (w_in_xfer && w_out_xfer) begin
                        main_q <= i_data;
                    end
                end
                TWO: begin
                    if (w_out_xfer) begin
                        state_q <= ONE;
                        main_q  <= skid_q;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_data  = main_q;
    assign o_occ   = state_q;

endmodule : skid_slice

`default_nettype wire

// File: rtl/registered_input_pipe.sv
// ============================================================================
// Module  : registered_input_pipe
// Brief   : Chain of STAGES skid slices with a total-occupancy counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module registered_input_pipe
    import registered_input_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [WIDTH-1:0]                  i_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [WIDTH-1:0]                  o_data,
    output logic [$clog2(2*STAGES+1)-1:0]     o_count
);

    localparam int CNT_W = count_width(STAGES);

    // Index k is the handshake between slice k-1 and slice k.
    logic [STAGES:0] w_valid;
    logic [STAGES:0] w_ready;
    logic [WIDTH-1:0] w_data [0:STAGES];
    logic [OCC_W-1:0] w_occ  [0:STAGES-1];
    logic [CNT_W-1:0] w_sum;

    assign w_valid[0]      = i_valid;
    assign w_data[0]       = i_data;
    assign w_ready[STAGES] = i_ready;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_slice
            skid_slice #(
                .WIDTH (WIDTH)
            ) u_slice (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_valid (w_valid[g]),
                .o_ready (w_ready[g]),
                .i_data  (w_data[g]),
                .o_valid (w_valid[g+1]),
                .i_ready (w_ready[g+1]),
                .o_data  (w_data[g+1]),
                .o_occ   (w_occ[g])
            );
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_sum = w_sum + CNT_W'(w_occ[k]);
        end
    end

    assign o_ready = w_ready[0];
    assign o_valid = w_valid[STAGES];
    assign o_data  = w_data[STAGES];
    assign o_count = w_sum;

endmodule : registered_input_pipe

`default_nettype wire

// File: tb/tb_registered_input_pipe.sv
// ============================================================================
// Module  : tb_registered_input_pipe
// Brief   : Directed and random scoreboard bench for registered_input_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registered_input_pipe;

    localparam int W    = 32;
    localparam int S    = 3;
    localparam int FULL = 2 * S;
    localparam int CW   = $clog2(2 * S + 1);

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data;
    logic          o_valid;
    logic          i_ready;
    logic [W-1:0]  o_data;
    logic [CW-1:0] o_count;

    registered_input_pipe #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } ent_t;

    ent_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   ins        = 0;
    int   outs       = 0;
    int   first_out  = 0;
    int   last_out   = 0;
    bit   lat_chk    = 1'b0;
    bit   stall_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, score the handshakes, advance.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        ent_t e;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        #1;
        check("count", 64'(o_count), 64'(sb.size()));
        if (sb.size() == FULL) check("full_ready", 64'(o_ready), 64'd0);
        if (stall_prev) check("stall_valid", 64'(o_valid), 64'd1);
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(o_valid), 64'd0);
            end else begin
                check("data", 64'(o_data), 64'(sb[0].data));
                if (i_ready) begin
                    e = sb.pop_front();
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(S));
                    if (outs == 0) first_out = cyc;
                    last_out = cyc;
                    outs++;
                end
            end
        end
        stall_prev = o_valid && !i_ready;
        if (i_valid && o_ready) begin
            sb.push_back('{data: d, cyc: cyc});
            ins++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_data",  64'(o_data),  64'd0);

        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        check("ready_after_edge", 64'(o_ready), 64'd1);
        @(negedge i_clk);

        // Three back-to-back words, minimum latency
        lat_chk = 1'b1;
        outs = 0;
        cycle(1'b1, 32'h1, 1'b1);
        cycle(1'b1, 32'h2, 1'b1);
        cycle(1'b1, 32'h3, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        lat_chk = 1'b0;
        check("latency_words_out", 64'(outs), 64'd3);
        check("latency_gap", 64'(last_out - first_out), 64'd2);

        // Fill with downstream stalled
        ins = 0;
        for (int k = 0; k < 10; k++) cycle(1'b1, 32'h100 + 32'(k), 1'b0);
        check("accepts_to_full", 64'(ins), 64'(FULL));
        check("full_count", 64'(o_count), 64'(FULL));
        check("full_ready_low", 64'(o_ready), 64'd0);

        // Drain from full with no bubbles
        outs = 0;
        repeat (10) cycle(1'b0, 32'hDEAD, 1'b1);
        check("drain_words", 64'(outs), 64'(FULL));
        check("drain_no_gap", 64'(last_out - first_out), 64'(FULL - 1));
        check("drain_count", 64'(o_count), 64'd0);
        check("drain_valid", 64'(o_valid), 64'd0);

        // Random handshakes
        ins = 0;
        guard = 0;
        while (ins < 10000 && guard < 60000) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("random_accepted", 64'(ins), 64'd10000);
        guard = 0;
        while ((sb.size() != 0 || o_valid) && guard < 100) begin
            cycle(1'b0, 32'($urandom), 1'b1);
            guard++;
        end
        check("random_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset with four words held
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h200 + 32'(k), 1'b0);
        check("pre_reset_count", 64'(o_count), 64'd4);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(o_valid), 64'd0);
        check("async_rst_ready", 64'(o_ready), 64'd0);
        check("async_rst_count", 64'(o_count), 64'd0);
        check("async_rst_data",  64'(o_data),  64'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        outs = 0;
        cycle(1'b1, 32'hC0FFEE, 1'b1);
        cycle(1'b1, 32'hC0FFEE, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        check("post_reset_words", 64'(outs), 64'd1);
        check("post_reset_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_registered_input_pipe

`default_nettype wire

// File: doc/registered_input_pipe.md
REGISTERED_INPUT_PIPE -- requirements
Module: registered_input_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, SHALL be >= 1.
REQ-002 Parameter STAGES, default 3: number of cascaded register slices, SHALL be >= 1.
REQ-003 Ports SHALL be the following.
- i_clk, input, 1 bit: sole clock, rising edge.
- i_rst, input, 1 bit: asynchronous, active-high reset.
- i_valid, input, 1 bit: upstream data valid.
- o_ready, output, 1 bit: block accepts data this cycle.
- i_data, input, WIDTH bits: upstream payload.
- o_valid, output, 1 bit: downstream data valid.
- i_ready, input, 1 bit: downstream accepts data.
- o_data, output, WIDTH bits: downstream payload.
- o_count, output, $clog2(2*STAGES+1) bits: total words held.

Function
REQ-004 A transfer SHALL occur on a rising edge when valid and ready are both high on that side.
REQ-005 Each slice SHALL hold up to 2 words: a main register and a skid register.
REQ-006 Each slice SHALL be a 3-state FSM:
- EMPTY to ONE on input transfer with no output transfer.
- ONE to TWO on input transfer without output transfer.
- ONE to EMPTY on output transfer without input transfer.
- TWO to ONE on output transfer; input is not accepted in TWO.
- ONE stays ONE on simultaneous input and output transfer.
REQ-007 A slice's ready SHALL be high in EMPTY and ONE, and low in TWO.
REQ-008 A slice's valid SHALL be high in ONE and TWO.
REQ-009 o_ready, o_valid and o_data SHALL be driven directly from flops; there SHALL be no combinational path from any input port to any output port.
REQ-010 Ordering SHALL be strict FIFO; a word SHALL never be dropped or duplicated.
REQ-011 On TWO to ONE, the skid word SHALL move to main.
REQ-012 Minimum latency i_valid to o_valid SHALL be STAGES cycles, i.e. one per slice with i_ready held high.
REQ-013 Throughput SHALL be one word per cycle in steady state with i_ready high.
REQ-014 o_count SHALL equal the sum of slice occupancies, updated the cycle after each transfer; maximum value is 2*STAGES.
REQ-015 When full (o_count == 2*STAGES), o_ready SHALL be low, and i_valid/i_data SHALL be ignored.
REQ-016 When empty, o_valid SHALL be low and o_data SHALL hold its last value.
REQ-017 o_data SHALL be stable while o_valid is high and i_ready is low.
REQ-018 i_data SHALL be sampled only on a transfer edge; changes to i_data while o_ready is low SHALL have no effect.

Reset
REQ-019 Asserting i_rst SHALL immediately, without a clock edge:
- put all slices in EMPTY;
- drive o_valid = 0, o_ready = 0, o_count = 0, o_data = 0.
REQ-020 o_ready SHALL go high on the first rising edge after i_rst deasserts.
REQ-021 Reset asserted mid-operation SHALL discard all held words; no stale word SHALL appear after reset.
REQ-022 Data registers SHALL be reset to 0.

Structure
REQ-023 Package registered_input_pipe_pkg SHALL hold:
- the slice state enum (EMPTY, ONE, TWO);
- the helper constant for count width.
REQ-024 Sub-module skid_slice SHALL implement one slice: WIDTH parameter, same handshake ports, plus a 2-bit occupancy output.
REQ-025 The top SHALL instantiate STAGES skid_slice instances in a generate chain and sum their occupancies.

Verification
REQ-026 Reset release, i_valid = 1, data 0x1, 0x2, 0x3 on consecutive cycles, i_ready = 1: o_data = 0x1, 0x2, 0x3 on cycles 3, 4, 5 after first accept, with o_valid high.
REQ-027 i_ready = 0, push continuously: o_ready falls after exactly 6 accepts (STAGES = 3), and o_count = 6.
REQ-028 From full, raise i_ready: 6 words emerge in order with no gap, o_count returns to 0, then o_valid = 0.
REQ-029 Random i_valid/i_ready at 50%, 10k words: scoreboard shows order and data exact, and o_data is stable whenever stalled.
REQ-030 Assert i_rst asynchronously with o_count = 4: outputs reach 0 before the next edge, and the first word after reset is new data.
REQ-031 Formal or lint check: no combinational path from i_ready to o_ready, or from i_valid to o_valid.
